// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM-stage requester and dmem_responder.
// The master modport is the pipeline side; the slave modport is the memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        read_mem;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp_valid;
    logic        mem_stall;
    logic        err;

    modport master (
        output req_valid, read_mem, write_mem, funct3, addr, wdata,
        input  req_ready, rdata, resp_valid, mem_stall, err
    );

    modport slave (
        input  req_valid, read_mem, write_mem, funct3, addr, wdata,
        output req_ready, rdata, resp_valid, mem_stall, err
    );
endinterface

// File: rtl/dmem_responder.sv
// RV32I data-memory responder: byte-enabled word array, two-cycle split for word-crossing accesses.
// Optional macro MISALIGN_TRAP_EN turns misaligned accesses into single-cycle error responses.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10
) (
    input logic           clk,
    input logic           rst,
    dmem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic {IDLE, SECOND} state_t;

    state_t                 state;
    logic [31:0]            mem [DEPTH];
    logic [31:0]            rdata_q;
    logic                   resp_valid_q;
    logic                   mem_stall_q;

    logic [DEPTH_LOG2-1:0]  sv_idx;
    logic [3:0]             sv_be_hi;
    logic [31:0]            sv_data_hi;
    logic [1:0]             sv_off;
    logic [1:0]             sv_size;
    logic                   sv_uns;
    logic                   sv_load;
    logic [31:0]            lo_word;

    logic [1:0]             off;
    logic [1:0]             size;
    logic                   uns;
    logic                   misaligned;
    logic                   accept;
    logic                   trap;
    logic                   split;
    logic [3:0]             lane_mask;
    logic [7:0]             be_wide;
    logic [63:0]            data_wide;
    logic [DEPTH_LOG2-1:0]  idx;
    logic [DEPTH_LOG2-1:0]  idx_next;
    logic [DEPTH_LOG2-1:0]  rd_idx;
    logic [31:0]            rd_word;
    logic [63:0]            window;
    logic [DEPTH_LOG2-1:0]  wr_idx;
    logic [3:0]             wr_be;
    logic [31:0]            wr_data;

    wire unused_addr_bits = &{1'b0, bus.addr[31:DEPTH_LOG2+2], 1'b0};

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz,
                                           input logic is_uns);
        logic [31:0] res;
        case (sz)
            2'd0:    res = is_uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'd1:    res = is_uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Size code 0=B, 1=H, 2=W; every funct3 with bit1 set is treated as a word.
    always_comb begin
        off        = bus.addr[1:0];
        size       = bus.funct3[1] ? 2'd2 : {1'b0, bus.funct3[0]};
        uns        = bus.funct3[2] & ~bus.funct3[1];
        misaligned = ((size == 2'd1) && (off == 2'b11)) || ((size == 2'd2) && (off != 2'b00));
        accept     = bus.req_valid && (state == IDLE) && (bus.read_mem ^ bus.write_mem);
        trap       = TRAP_EN && misaligned;
        split      = !TRAP_EN && misaligned;
        case (size)
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        be_wide   = {4'b0, lane_mask} << off;
        data_wide = {32'b0, bus.wdata} << {off, 3'b000};
        idx       = bus.addr[DEPTH_LOG2+1:2];
        idx_next  = idx + DEPTH_LOG2'(1);
    end

    // In SECOND the array port belongs to the held second-word access.
    always_comb begin
        rd_idx  = (state == SECOND) ? sv_idx : idx;
        rd_word = mem[rd_idx];
        window  = {rd_word, lo_word} >> {sv_off, 3'b000};
        wr_idx  = idx;
        wr_be   = 4'b0000;
        wr_data = data_wide[31:0];
        if (state == SECOND) begin
            wr_idx  = sv_idx;
            wr_data = sv_data_hi;
            wr_be   = sv_load ? 4'b0000 : sv_be_hi;
        end else if (accept && bus.write_mem && !trap) begin
            wr_be = be_wide[3:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rdata_q      <= 32'b0;
            resp_valid_q <= 1'b0;
            mem_stall_q  <= 1'b0;
            sv_idx       <= '0;
            sv_be_hi     <= 4'b0;
            sv_data_hi   <= 32'b0;
            sv_off       <= 2'b0;
            sv_size      <= 2'b0;
            sv_uns       <= 1'b0;
            sv_load      <= 1'b0;
            lo_word      <= 32'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (trap) begin
                            resp_valid_q <= 1'b1;
                            rdata_q      <= 32'b0;
                        end else if (split) begin
                            state       <= SECOND;
                            mem_stall_q <= 1'b1;
                            sv_idx      <= idx_next;
                            sv_be_hi    <= be_wide[7:4];
                            sv_data_hi  <= data_wide[63:32];
                            sv_off      <= off;
                            sv_size     <= size;
                            sv_uns      <= uns;
                            sv_load     <= bus.read_mem;
                            lo_word     <= rd_word;
                        end else begin
                            resp_valid_q <= 1'b1;
                            if (bus.read_mem)
                                rdata_q <= extend(rd_word >> {off, 3'b000}, size, uns);
                        end
                    end
                end
                SECOND: begin
                    state        <= IDLE;
                    mem_stall_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    if (sv_load) rdata_q <= extend(window[31:0], sv_size, sv_uns);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= accept && misaligned;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.req_ready  = (state == IDLE);
    assign bus.rdata      = rdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.mem_stall  = mem_stall_q;
endmodule
